// File: rtl/uart_rx_ctrl.sv
// UART receive controller.
// Times the sampling of an asynchronous RX line and drives the baud-enable
// of an external SIPO shift register. Once a full frame has been shifted in,
// it checks the start and stop bits, then either publishes the data byte or
// flags a framing error. A line held low after the frame counts as a break,
// and the controller waits for the line to return high before it rearms.
module uart_rx_ctrl #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       serial_in,
   input  logic [9:0] frame_in,
   output logic       shift_en,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       FRAME_BITS = 4'd10;

   typedef enum logic [2:0] {
      IDLE,
      START,
      SHIFT,
      CHECK,
      BREAK
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       bitCnt_q;
   logic             shiftEn_q;
   logic [7:0]       data_q;
   logic             valid_q;
   logic             frameErr_q;
   logic             syncMeta_q;
   logic             rxSync_q;

   // Two-flop synchronizer for the asynchronous RX line; it resets to the idle
   // level so that reset can never look like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         syncMeta_q <= 1'b1;
         rxSync_q   <= 1'b1;
      end else begin
         syncMeta_q <= serial_in;
         rxSync_q   <= syncMeta_q;
      end
   end

   // Receive FSM: half-bit wait to mid start bit, then one shift strobe per
   // bit period; it idles in SHIFT for one cycle after the tenth strobe so the
   // shift register has settled before CHECK inspects the frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bitCnt_q   <= '0;
         shiftEn_q  <= 1'b0;
         data_q     <= 8'h00;
         valid_q    <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         shiftEn_q  <= 1'b0;
         valid_q    <= 1'b0;
         frameErr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rxSync_q) begin
                  state_q <= START;
                  cnt_q   <= HALF_LOAD;
               end
            end
            START: begin
               if (cnt_q == '0) begin
                  if (!rxSync_q) begin
                     shiftEn_q <= 1'b1;
                     bitCnt_q  <= 4'd1;
                     cnt_q     <= FULL_LOAD;
                     state_q   <= SHIFT;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            SHIFT: begin
               if (bitCnt_q == FRAME_BITS) begin
                  state_q <= CHECK;
               end else if (cnt_q == '0) begin
                  shiftEn_q <= 1'b1;
                  bitCnt_q  <= bitCnt_q + 4'd1;
                  cnt_q     <= FULL_LOAD;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            CHECK: begin
               if (!frame_in[0] && frame_in[9]) begin
                  data_q  <= frame_in[8:1];
                  valid_q <= 1'b1;
               end else begin
                  frameErr_q <= 1'b1;
               end
               bitCnt_q <= '0;
               state_q  <= rxSync_q ? IDLE : BREAK;
            end
            BREAK: begin
               if (rxSync_q) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign shift_en   = shiftEn_q;
   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign frame_err  = frameErr_q;
   assign busy       = (state_q != IDLE);

endmodule
